// File: rtl/jt12_pkg.sv
// jt12_pkg: shared constants for the JT12 CPU-side timer register front end.
//   - timer register addresses (part I)
//   - CPU port address encodings
//   - channel-3 mode encodings
//   - bit positions inside the status read byte
package jt12_pkg;

  // Timer registers, reachable only through part I
  localparam logic [7:0] REG_TA_HI = 8'h24;
  localparam logic [7:0] REG_TA_LO = 8'h25;
  localparam logic [7:0] REG_TB    = 8'h26;
  localparam logic [7:0] REG_TMODE = 8'h27;

  // CPU port addresses: bit 0 selects address/data, bit 1 selects part
  localparam logic [1:0] PORT_ADDR_P1 = 2'd0;
  localparam logic [1:0] PORT_DATA_P1 = 2'd1;
  localparam logic [1:0] PORT_ADDR_P2 = 2'd2;
  localparam logic [1:0] PORT_DATA_P2 = 2'd3;

  typedef enum logic [1:0] {
    NORMAL  = 2'b00,
    SPECIAL = 2'b01,
    CSM     = 2'b10
  } ch3_mode_t;

  // Status byte layout: {busy, 5'b0, flag_B, flag_A}
  localparam int STAT_BUSY   = 7;
  localparam int STAT_FLAG_B = 1;
  localparam int STAT_FLAG_A = 0;

  function automatic logic is_data_port(input logic [1:0] addr);
    return addr[0];
  endfunction

endpackage

// File: rtl/jt12_timer_regs_if.sv
// jt12_timer_regs_if: 4-address CPU write/status port.
//   cpu_cs_n  chip select, active-low
//   cpu_wr_n  write strobe, active-low
//   cpu_addr  0/1 = addr/data part I, 2/3 = addr/data part II
//   cpu_din   write data
//   cpu_dout  status byte returned to the CPU
interface jt12_timer_regs_if;
  logic       cpu_cs_n;
  logic       cpu_wr_n;
  logic [1:0] cpu_addr;
  logic [7:0] cpu_din;
  logic [7:0] cpu_dout;

  modport master (
    output cpu_cs_n, cpu_wr_n, cpu_addr, cpu_din,
    input  cpu_dout
  );

  modport slave (
    input  cpu_cs_n, cpu_wr_n, cpu_addr, cpu_din,
    output cpu_dout
  );
endinterface

// File: rtl/jt12_busy_cnt.sv
// jt12_busy_cnt: write-busy countdown.
//   clk, rst  system clock, async active-high reset
//   clk_en    FM clock enable; one decrement per tick
//   reload    data-port write accepted this cycle
//   busy      high while the counter is non-zero
module jt12_busy_cnt #(
  parameter int BUSY_CYCLES = 32,
  parameter int BUSY_W      = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_en,
  input  logic reload,
  output logic busy
);

  localparam logic [BUSY_W-1:0] LOAD_VAL = BUSY_W'(BUSY_CYCLES);
  localparam logic [BUSY_W-1:0] ONE      = BUSY_W'(1);

  logic [BUSY_W-1:0] cnt;

  // A write landing on a clk_en tick reloads rather than decrements.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (reload) begin
      cnt <= LOAD_VAL;
    end else if (clk_en && cnt != '0) begin
      cnt <= cnt - ONE;
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/jt12_timer_regs.sv
// jt12_timer_regs: CPU-side register front end for the FM timer block.
//   clk, rst        system clock, async active-high reset
//   clk_en          FM clock enable (busy countdown, CSM detect)
//   cpu             CPU port (slave side of jt12_timer_regs_if)
//   flag_A/flag_B   timer flags, reflected in the status byte
//   overflow_A      timer A overflow, source of the CSM key-on
//   value_A/value_B timer presets NA/NB
//   load_A/load_B   hold timers at preset while stopped
//   clr_flag_A/B    one-cycle flag clear pulses from reg 0x27
//   enable_irq_A/B  IRQ enables
//   ch3_mode        reg 0x27 bits 7:6
//   csm_keyon       one-cycle CSM key-on pulse
//   busy            write-busy flag
module jt12_timer_regs
  import jt12_pkg::*;
#(
  parameter int BUSY_CYCLES = 32,
  parameter int BUSY_W      = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_en,
  jt12_timer_regs_if.slave        cpu,
  input  logic                    flag_A,
  input  logic                    flag_B,
  input  logic                    overflow_A,
  output logic [9:0]              value_A,
  output logic [7:0]              value_B,
  output logic                    load_A,
  output logic                    load_B,
  output logic                    clr_flag_A,
  output logic                    clr_flag_B,
  output logic                    enable_irq_A,
  output logic                    enable_irq_B,
  output logic [1:0]              ch3_mode,
  output logic                    csm_keyon,
  output logic                    busy
);

  logic       we, we_d, wr_edge;
  logic       addr_wr, data_wr, timer_wr, mode_wr;
  logic [7:0] reg_addr;
  logic       part;
  logic       run_A;
  logic       csm_hit;
  logic [7:0] status;

  assign we      = ~cpu.cpu_cs_n & ~cpu.cpu_wr_n;
  assign wr_edge = we & ~we_d;
  assign addr_wr = wr_edge & ~is_data_port(cpu.cpu_addr);
  assign data_wr = wr_edge &  is_data_port(cpu.cpu_addr);

  // Timer registers live in part I only; both the latched part and the
  // port used for the data write must say so.
  assign timer_wr = data_wr & ~part & (cpu.cpu_addr == PORT_DATA_P1);
  assign mode_wr  = timer_wr & (reg_addr == REG_TMODE);

  assign run_A = ~load_A;

  // Registered mode is used, but a same-cycle write leaving CSM vetoes it.
  assign csm_hit = clk_en & overflow_A & run_A & (ch3_mode == CSM)
                 & ~(mode_wr & (cpu.cpu_din[7:6] != CSM));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // we_d resets high so a strobe still held when rst drops is not
      // mistaken for a fresh write.
      we_d         <= 1'b1;
      reg_addr     <= 8'h00;
      part         <= 1'b0;
      value_A      <= 10'd0;
      value_B      <= 8'd0;
      load_A       <= 1'b1;
      load_B       <= 1'b1;
      clr_flag_A   <= 1'b0;
      clr_flag_B   <= 1'b0;
      enable_irq_A <= 1'b0;
      enable_irq_B <= 1'b0;
      ch3_mode     <= 2'b00;
      csm_keyon    <= 1'b0;
    end else begin
      we_d       <= we;
      clr_flag_A <= 1'b0;
      clr_flag_B <= 1'b0;
      csm_keyon  <= csm_hit;

      if (addr_wr) begin
        reg_addr <= cpu.cpu_din;
        part     <= cpu.cpu_addr[1];
      end

      if (timer_wr) begin
        case (reg_addr)
          REG_TA_HI: value_A[9:2] <= cpu.cpu_din;
          REG_TA_LO: value_A[1:0] <= cpu.cpu_din[1:0];
          REG_TB:    value_B      <= cpu.cpu_din;
          REG_TMODE: begin
            ch3_mode     <= cpu.cpu_din[7:6];
            clr_flag_B   <= cpu.cpu_din[5];
            clr_flag_A   <= cpu.cpu_din[4];
            enable_irq_B <= cpu.cpu_din[3];
            enable_irq_A <= cpu.cpu_din[2];
            load_B       <= ~cpu.cpu_din[1];
            load_A       <= ~cpu.cpu_din[0];
          end
          default: ;
        endcase
      end
    end
  end

  jt12_busy_cnt #(
    .BUSY_CYCLES (BUSY_CYCLES),
    .BUSY_W      (BUSY_W)
  ) u_busy_cnt (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .reload (data_wr),
    .busy   (busy)
  );

  always_comb begin
    status              = 8'h00;
    status[STAT_BUSY]   = busy;
    status[STAT_FLAG_B] = flag_B;
    status[STAT_FLAG_A] = flag_A;
  end

  assign cpu.cpu_dout = status;

endmodule

// File: tb/tb_jt12_timer_regs.sv
module tb_jt12_timer_regs;
  localparam int BUSY_CYCLES = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       clk_en;
  logic       flag_A, flag_B, overflow_A;
  logic [9:0] value_A;
  logic [7:0] value_B;
  logic       load_A, load_B, clr_flag_A, clr_flag_B;
  logic       enable_irq_A, enable_irq_B;
  logic [1:0] ch3_mode;
  logic       csm_keyon, busy;

  jt12_timer_regs_if cpu();

  jt12_timer_regs #(.BUSY_CYCLES(BUSY_CYCLES), .BUSY_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .clk_en       (clk_en),
    .cpu          (cpu),
    .flag_A       (flag_A),
    .flag_B       (flag_B),
    .overflow_A   (overflow_A),
    .value_A      (value_A),
    .value_B      (value_B),
    .load_A       (load_A),
    .load_B       (load_B),
    .clr_flag_A   (clr_flag_A),
    .clr_flag_B   (clr_flag_B),
    .enable_irq_A (enable_irq_A),
    .enable_irq_B (enable_irq_B),
    .ch3_mode     (ch3_mode),
    .csm_keyon    (csm_keyon),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          clr_a_cnt = 0, clr_b_cnt = 0, csm_cnt = 0, en_busy_cnt = 0;
  logic [31:0] exp_q[$];

  // Single time base: every stimulus step goes through here. clk_en for the
  // upcoming edge is known after each call (high on every third edge).
  task automatic tick();
    logic en_now, busy_before;
    en_now      = clk_en;
    busy_before = busy;
    @(posedge clk);
    #1;
    if (en_now && busy_before) en_busy_cnt++;
    if (clr_flag_A) clr_a_cnt++;
    if (clr_flag_B) clr_b_cnt++;
    if (csm_keyon)  csm_cnt++;
    cyc++;
    clk_en = (cyc % 3 == 0);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    cpu.cpu_addr = a;
    cpu.cpu_din  = d;
    cpu.cpu_cs_n = 1'b0;
    cpu.cpu_wr_n = 1'b0;
    tick();
    if (a[0]) en_busy_cnt = 0;
    cpu.cpu_cs_n = 1'b1;
    cpu.cpu_wr_n = 1'b1;
    tick();
  endtask

  task automatic reg_write(input logic [7:0] r, input logic [7:0] d);
    bus_write(2'd0, r);
    bus_write(2'd1, d);
  endtask

  task automatic wait_busy_low(output logic ok);
    int g = 0;
    while (busy && g < 1000) begin
      tick();
      g++;
    end
    ok = !busy;
  endtask

  task automatic test_reset();
    logic [31:0] got, want;
    rst = 1'b1;
    cpu.cpu_cs_n = 1'b1; cpu.cpu_wr_n = 1'b1; cpu.cpu_addr = 2'd0; cpu.cpu_din = 8'h00;
    flag_A = 1'b0; flag_B = 1'b0; overflow_A = 1'b0; clk_en = 1'b0;
    exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(0);
    exp_q.push_back(0); exp_q.push_back(8'h00);
    tick(); tick();
    want = exp_q.pop_front(); got = 32'(load_A); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL reset_load_A: got %0h want %0h", got, want); end
    want = exp_q.pop_front(); got = 32'(load_B); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL reset_load_B: got %0h want %0h", got, want); end
    want = exp_q.pop_front(); got = 32'(value_A); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL reset_value_A: got %0h want %0h", got, want); end
    want = exp_q.pop_front(); got = 32'(busy); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL reset_busy: got %0h want %0h", got, want); end
    want = exp_q.pop_front(); got = 32'(cpu.cpu_dout); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL reset_dout: got %0h want %0h", got, want); end
    rst = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic test_timer_a();
    logic [31:0] got, want;
    logic        ok;
    reg_write(8'h24, 8'hFF);
    reg_write(8'h25, 8'h03);
    exp_q.push_back(10'h3FF); exp_q.push_back(1); exp_q.push_back(BUSY_CYCLES);
    want = exp_q.pop_front(); got = 32'(value_A); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL ta_value_A: got %0h want %0h", got, want); end
    want = exp_q.pop_front(); got = 32'(busy); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL ta_busy_set: got %0h want %0h", got, want); end
    wait_busy_low(ok);
    if (!ok) begin n_fail++; $display("FAIL ta_busy_timeout: got busy 1 want 0"); end
    want = exp_q.pop_front(); got = 32'(en_busy_cnt); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL ta_busy_ticks: got %0d want %0d", got, want); end
  endtask

  task automatic test_control();
    logic [31:0] got, want;
    clr_a_cnt = 0; clr_b_cnt = 0;
    reg_write(8'h27, 8'h3F);
    tick(); tick();
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(1);
    exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(1);
    want = exp_q.pop_front(); got = 32'(load_A); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL ctl_load_A: got %0h want %0h", got, want); end
    want = exp_q.pop_front(); got = 32'(load_B); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL ctl_load_B: got %0h want %0h", got, want); end
    want = exp_q.pop_front(); got = 32'(enable_irq_A); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL ctl_irq_A: got %0h want %0h", got, want); end
    want = exp_q.pop_front(); got = 32'(enable_irq_B); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL ctl_irq_B: got %0h want %0h", got, want); end
    want = exp_q.pop_front(); got = 32'(clr_a_cnt); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL ctl_clr_A_cycles: got %0d want %0d", got, want); end
    want = exp_q.pop_front(); got = 32'(clr_b_cnt); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL ctl_clr_B_cycles: got %0d want %0d", got, want); end
    clr_a_cnt = 0; clr_b_cnt = 0;
    reg_write(8'h27, 8'h0F);
    tick(); tick();
    exp_q.push_back(0); exp_q.push_back(0);
    want = exp_q.pop_front(); got = 32'(clr_a_cnt + clr_b_cnt); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL ctl_no_clear: got %0d want %0d", got, want); end
    want = exp_q.pop_front(); got = 32'(load_A); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL ctl_still_running: got %0h want %0h", got, want); end
  endtask

  task automatic test_held_strobe();
    logic [31:0] got, want;
    logic        ok;
    bus_write(2'd0, 8'h26);
    cpu.cpu_addr = 2'd1; cpu.cpu_din = 8'h80;
    cpu.cpu_cs_n = 1'b0; cpu.cpu_wr_n = 1'b0;
    tick();
    en_busy_cnt = 0;
    repeat (9) tick();
    cpu.cpu_cs_n = 1'b1; cpu.cpu_wr_n = 1'b1;
    tick();
    exp_q.push_back(8'h80); exp_q.push_back(BUSY_CYCLES);
    want = exp_q.pop_front(); got = 32'(value_B); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL held_value_B: got %0h want %0h", got, want); end
    wait_busy_low(ok);
    if (!ok) begin n_fail++; $display("FAIL held_busy_timeout: got busy 1 want 0"); end
    want = exp_q.pop_front(); got = 32'(en_busy_cnt); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL held_busy_ticks: got %0d want %0d", got, want); end
  endtask

  task automatic csm_overflow_window();
    int g = 0;
    while (!clk_en && g < 10) begin tick(); g++; end
    overflow_A = 1'b1;
    repeat (3) tick();
    overflow_A = 1'b0;
    tick(); tick();
  endtask

  task automatic test_csm();
    logic [31:0] got, want;
    int g;
    reg_write(8'h27, 8'h81);
    csm_cnt = 0;
    csm_overflow_window();
    exp_q.push_back(1);
    want = exp_q.pop_front(); got = 32'(csm_cnt); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL csm_single_pulse: got %0d want %0d", got, want); end

    reg_write(8'h27, 8'h01);
    csm_cnt = 0;
    csm_overflow_window();
    exp_q.push_back(0);
    want = exp_q.pop_front(); got = 32'(csm_cnt); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL csm_normal_mode: got %0d want %0d", got, want); end

    // Write leaving CSM lands on the same edge as clk_en & overflow_A.
    reg_write(8'h27, 8'h81);
    csm_cnt = 0;
    g = 0;
    while (!clk_en && g < 10) begin tick(); g++; end
    cpu.cpu_addr = 2'd1; cpu.cpu_din = 8'h01;
    cpu.cpu_cs_n = 1'b0; cpu.cpu_wr_n = 1'b0;
    overflow_A = 1'b1;
    tick();
    cpu.cpu_cs_n = 1'b1; cpu.cpu_wr_n = 1'b1;
    overflow_A = 1'b0;
    tick(); tick();
    exp_q.push_back(0); exp_q.push_back(0);
    want = exp_q.pop_front(); got = 32'(csm_cnt); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL csm_veto_same_cycle: got %0d want %0d", got, want); end
    want = exp_q.pop_front(); got = 32'(ch3_mode); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL csm_mode_left: got %0h want %0h", got, want); end
  endtask

  task automatic test_part2();
    logic [31:0] got, want;
    bus_write(2'd2, 8'h24);
    bus_write(2'd3, 8'h55);
    flag_A = 1'b1; flag_B = 1'b0;
    #1;
    exp_q.push_back(10'h3FF); exp_q.push_back(1); exp_q.push_back(8'h81);
    want = exp_q.pop_front(); got = 32'(value_A); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL p2_value_A: got %0h want %0h", got, want); end
    want = exp_q.pop_front(); got = 32'(busy); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL p2_busy: got %0h want %0h", got, want); end
    want = exp_q.pop_front(); got = 32'(cpu.cpu_dout); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL p2_status: got %0h want %0h", got, want); end
    flag_A = 1'b0;
  endtask

  task automatic test_reset_midwrite();
    logic [31:0] got, want;
    bus_write(2'd0, 8'h27);
    clr_a_cnt = 0; clr_b_cnt = 0;
    cpu.cpu_addr = 2'd1; cpu.cpu_din = 8'h30;
    cpu.cpu_cs_n = 1'b0; cpu.cpu_wr_n = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    repeat (3) tick();
    cpu.cpu_cs_n = 1'b1; cpu.cpu_wr_n = 1'b1;
    tick();
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(1);
    want = exp_q.pop_front(); got = 32'(busy); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL rstw_busy: got %0h want %0h", got, want); end
    want = exp_q.pop_front(); got = 32'(clr_a_cnt + clr_b_cnt); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL rstw_no_pulse: got %0d want %0d", got, want); end
    want = exp_q.pop_front(); got = 32'(load_A); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL rstw_load_A: got %0h want %0h", got, want); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_timer_a();
    test_control();
    test_held_strobe();
    test_csm();
    test_part2();
    test_reset_midwrite();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
